// File: rtl/esp_uart.sv
`default_nettype none
// ============================================================================
//  Module      : esp_uart
//  Description : CPU-mapped UART link to an ESP co-processor. 9-bit frames
//                (8 data bits plus start-of-message flag), TX/RX FIFOs,
//                CTS flow control on transmit, sticky overflow/framing flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module esp_uart #(
    parameter int CLK_HZ     = 28636360,
    parameter int BAUD       = 1789772,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_addr,
    input  logic        bus_strobe,
    input  logic        bus_wren,
    input  logic [31:0] bus_wrdata,
    output logic [31:0] bus_rddata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    input  logic        uart_cts_n
);

    // Bit period in clocks, rounded to nearest
    localparam int c_DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_CW   = c_AW + 1;
    localparam int c_TW   = $clog2(c_DIV);

    localparam logic [c_TW-1:0] c_TICK = c_TW'(c_DIV - 1);
    localparam logic [c_TW-1:0] c_HALF = c_TW'(c_DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    // Shared state encoding for the TX and RX machines
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_wr_data, w_wr_stat, w_rd_data, w_rd_stat;
    assign w_wr_data = bus_strobe &  bus_wren &  bus_addr;
    assign w_wr_stat = bus_strobe &  bus_wren & ~bus_addr;
    assign w_rd_data = bus_strobe & ~bus_wren &  bus_addr;
    assign w_rd_stat = bus_strobe & ~bus_wren & ~bus_addr;

    logic w_unused_wr;
    assign w_unused_wr = &{1'b0, bus_wrdata[31:9]};

    // ------------------------------------------------------------------
    // Synchronizers (preset high so reset looks like an idle line / no CTS)
    // ------------------------------------------------------------------
    logic r_rx_s1, r_rx_s2, r_rx_prev, r_cts_s1, r_cts_s2;

    // Two-flop synchronizers for rxd and cts_n, plus rxd edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cts_s1  <= 1'b1;
            r_cts_s2  <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_cts_s1  <= uart_cts_n;
            r_cts_s2  <= r_cts_s1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [8:0]      r_txf_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_txf_wp, r_txf_rp;
    logic [c_CW-1:0] r_txf_cnt;
    logic            w_txf_full, w_txf_push, w_txf_pop;

    assign w_txf_full = (r_txf_cnt == c_FULL);
    assign w_txf_push = w_wr_data & ~w_txf_full;

    // TX FIFO storage; written only on an accepted DATA write
    always_ff @(posedge clk) begin
        if (w_txf_push) r_txf_mem[r_txf_wp] <= bus_wrdata[8:0];
    end

    // TX FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
            if (w_txf_pop)  r_txf_rp <= r_txf_rp + 1'b1;
            case ({w_txf_push, w_txf_pop})
                2'b10:   r_txf_cnt <= r_txf_cnt + c_CW'(1);
                2'b01:   r_txf_cnt <= r_txf_cnt - c_CW'(1);
                default: r_txf_cnt <= r_txf_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX state machine
    // ------------------------------------------------------------------
    logic [1:0]      r_tx_state;
    logic [c_TW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [8:0]      r_tx_shift;
    logic            r_txd;
    logic            w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == c_TICK);
    // A new frame launches from IDLE, or straight out of the last stop-bit clock
    assign w_txf_pop = (r_txf_cnt != '0) & ~r_cts_s2 &
                       ((r_tx_state == c_S_IDLE) | ((r_tx_state == c_S_STOP) & w_tx_tick));
    assign uart_txd  = r_txd;

    // TX frame sequencer: start bit, 9 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= c_S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                c_S_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_txf_pop) begin
                        r_tx_state <= c_S_START;
                        r_tx_shift <= r_txf_mem[r_txf_rp];
                        r_txd      <= 1'b0;
                    end
                end
                c_S_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= c_S_DATA;
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'd8) begin
                            r_tx_state <= c_S_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (w_txf_pop) begin
                            r_tx_state <= c_S_START;
                            r_tx_shift <= r_txf_mem[r_txf_rp];
                            r_txd      <= 1'b0;
                        end else begin
                            r_tx_state <= c_S_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX state machine
    // ------------------------------------------------------------------
    logic [1:0]      r_rx_state;
    logic [c_TW-1:0] r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [8:0]      r_rx_shift;
    logic            r_rx_brk;
    logic            w_rx_tick, w_rx_stop_end;

    assign w_rx_tick     = (r_rx_cnt == c_TICK);
    assign w_rx_stop_end = (r_rx_state == c_S_STOP) & ~r_rx_brk & w_rx_tick;

    // RX frame sampler; r_rx_brk holds STOP after a bad stop bit until the line idles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= c_S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_brk   <= 1'b0;
        end else begin
            case (r_rx_state)
                c_S_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_brk <= 1'b0;
                    if (r_rx_prev & ~r_rx_s2) r_rx_state <= c_S_START;
                end
                c_S_START: begin
                    if (r_rx_cnt == c_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_s2 ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[8:1]};
                        if (r_rx_bit == 4'd8) r_rx_state <= c_S_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_brk) begin
                        if (r_rx_s2) r_rx_state <= c_S_IDLE;
                    end else if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        if (r_rx_s2) r_rx_state <= c_S_IDLE;
                        else         r_rx_brk   <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [8:0]      r_rxf_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rxf_wp, r_rxf_rp;
    logic [c_CW-1:0] r_rxf_cnt;
    logic            w_rxf_full, w_rxf_nempty, w_rxf_push, w_rxf_pop;

    assign w_rxf_full   = (r_rxf_cnt == c_FULL);
    assign w_rxf_nempty = (r_rxf_cnt != '0);
    assign w_rxf_push   = w_rx_stop_end & r_rx_s2 & ~w_rxf_full;
    assign w_rxf_pop    = w_rd_data & w_rxf_nempty;

    // RX FIFO storage; written on a good stop bit with room available
    always_ff @(posedge clk) begin
        if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_shift;
    end

    // RX FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
            if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + 1'b1;
            case ({w_rxf_push, w_rxf_pop})
                2'b10:   r_rxf_cnt <= r_rxf_cnt + c_CW'(1);
                2'b01:   r_rxf_cnt <= r_rxf_cnt - c_CW'(1);
                default: r_rxf_cnt <= r_rxf_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status flags and read data
    // ------------------------------------------------------------------
    logic        r_ovf, r_fe;
    logic [31:0] r_rddata;
    logic [31:0] w_status;

    assign w_status   = {28'd0, r_fe, r_ovf, w_txf_full, w_rxf_nempty};
    assign bus_rddata = r_rddata;

    // Sticky error flags; a new error in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovf <= (w_rx_stop_end & r_rx_s2 & w_rxf_full) |
                     (r_ovf & ~(w_wr_stat & bus_wrdata[2]));
            r_fe  <= (w_rx_stop_end & ~r_rx_s2) |
                     (r_fe & ~(w_wr_stat & bus_wrdata[3]));
        end
    end

    // Registered read port; value holds until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rddata <= '0;
        end else if (w_rd_stat) begin
            r_rddata <= w_status;
        end else if (w_rd_data) begin
            r_rddata <= w_rxf_nempty ? {23'd0, r_rxf_mem[r_rxf_rp]} : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: doc/esp_uart.md
ESP_UART -- requirements
Module: esp_uart

Interface
REQ-001 Parameter CLK_HZ, default 28636360; system clock frequency in Hz.
REQ-002 Parameter BAUD, default 1789772; serial bit rate; DIV = CLK_HZ/BAUD rounded to nearest, DIV >= 4.
REQ-003 Parameter FIFO_DEPTH, default 16; entries per TX and RX FIFO, power of two.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 bus_addr  input  1  register select: 0 = STATUS (CPU offset 0x0), 1 = DATA (CPU offset 0x4).
REQ-007 bus_strobe  input  1  one-cycle access request.
REQ-008 bus_wren  input  1  with bus_strobe: 1 = write, 0 = read.
REQ-009 bus_wrdata  input  32  write data; bits [8:0] used.
REQ-010 bus_rddata  output  32  registered read data.
REQ-011 uart_rxd  input  1  serial input from ESP, idle high, asynchronous.
REQ-012 uart_txd  output  1  serial output to ESP, idle high.
REQ-013 uart_cts_n  input  1  ESP ready; low permits a new TX frame to start.

Function
REQ-014 Frame format, both directions: start (0), 9 data bits LSB first (bits [7:0] byte, bit 8 start-of-message flag), one stop (1); each bit DIV clocks.
REQ-015 STATUS read: bit0 = RX FIFO not empty, bit1 = TX FIFO full, bit2 = RX overflow (sticky), bit3 = RX framing error (sticky), bits [31:4] = 0.
REQ-016 STATUS write: bit2 = 1 clears overflow, bit3 = 1 clears framing error; other bits ignored.
REQ-017 DATA write: pushes bus_wrdata[8:0] into TX FIFO; write while TX FIFO full is dropped, no state change.
REQ-018 DATA read: bus_rddata[8:0] = RX FIFO head, [31:9] = 0, head popped same cycle; read while empty returns 0 and pops nothing.
REQ-019 bus_rddata valid on cycle after bus_strobe (1-cycle latency), holds value until next read.
REQ-020 TX FSM states IDLE, START, DATA, STOP; IDLE->START when TX FIFO not empty and uart_cts_n low (sampled through 2-flop synchronizer), entry popped on that transition.
REQ-021 uart_cts_n rising mid-frame does not abort the frame; next frame waits.
REQ-022 Back-to-back frames: STOP->START directly when FIFO not empty and CTS permits; no extra idle bit.
REQ-023 uart_rxd passes through 2-flop synchronizer before any use.
REQ-024 RX FSM states IDLE, START, DATA, STOP; falling edge in IDLE -> START; at DIV/2 re-sample, high returns to IDLE (glitch reject).
REQ-025 RX samples each data bit and stop bit at bit centre (DIV clocks apart).
REQ-026 Stop bit 1: push 9-bit word to RX FIFO; full FIFO -> word discarded, overflow set.
REQ-027 Stop bit 0: word discarded, framing error set, RX waits for rxd high before IDLE.
REQ-028 RX FIFO push and CPU pop in same cycle: both occur, count unchanged; same for TX push/pop.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1, full = count == FIFO_DEPTH.

Reset
REQ-030 reset_n low asynchronously: both FSMs IDLE, FIFOs empty, sticky flags 0, bus_rddata 0, uart_txd 1, synchronizers preset to 1.
REQ-031 Reset mid-frame: uart_txd returns high within the assertion; partial RX word discarded.

Verification
REQ-032 Write DATA 0x100 then 0x012, cts_n low -> txd shows two back-to-back frames, bit8 = 1 then 0, 11*DIV clocks each.
REQ-033 ESP sends 0x1A5 on rxd -> STATUS reads 0x1; DATA read returns 0x000001A5 next cycle; STATUS then 0x0.
REQ-034 cts_n high, write 17 words (depth 16) -> txd idle, STATUS bit1 = 1, 17th dropped; cts_n low -> exactly 16 frames.
REQ-035 Send 17 RX frames without reads -> 16 stored, STATUS = 0x5; write STATUS 0x4 -> bit2 clears.
REQ-036 RX frame with stop bit 0, then 1-bit-time low glitch < DIV/2 -> STATUS bit3 = 1, FIFO empty, no spurious word.
REQ-037 reset_n low during TX data bit -> txd = 1 immediately, STATUS 0x0 after release.
